// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit holding the architectural HI/LO registers
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDUctrl,
   input  logic        start,
   input  logic        req,
   input  logic        rd_sel,
   output logic [31:0] MDUout,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t         state;
   logic [CW-1:0]  cnt;
   logic [31:0]    temp_hi, temp_lo;
   logic           wr_en;
   logic           accept, is_mul, is_div, sgn, div_zero;
   logic [31:0]    ua, ub, ub_nz, uq, ur, q, r;
   logic [63:0]    prod, res;
   // Decode the request and form the 64-bit result from the operands at the accepting edge
   always_comb begin
      accept   = start & ~req & ~busy;
      is_mul   = (MDUctrl == 3'd1) || (MDUctrl == 3'd2);
      is_div   = (MDUctrl == 3'd3) || (MDUctrl == 3'd4);
      sgn      = MDUctrl == 3'd3;
      div_zero = B == 32'd0;
      prod     = (MDUctrl == 3'd1) ? {{32{A[31]}}, A} * {{32{B[31]}}, B} : {32'd0, A} * {32'd0, B};
      ua       = (sgn & A[31]) ? -A : A;
      ub       = (sgn & B[31]) ? -B : B;
      ub_nz    = div_zero ? 32'd1 : ub;
      uq       = ua / ub_nz;
      ur       = ua % ub_nz;
      q        = (sgn & (A[31] ^ B[31])) ? -uq : uq;
      r        = (sgn & A[31]) ? -ur : ur;
      res      = is_mul ? prod : {r, q};
   end
   // Control FSM: capture result on accept, count down, commit HI/LO when the count expires
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         temp_hi <= '0;
         temp_lo <= '0;
         wr_en   <= 1'b0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               if (is_mul || is_div) begin
                  temp_hi <= res[63:32];
                  temp_lo <= res[31:0];
                  wr_en   <= ~(is_div & div_zero);
                  cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                  busy    <= 1'b1;
                  state   <= RUN;
               end
               if (MDUctrl == 3'd5) HI <= A;
               if (MDUctrl == 3'd6) LO <= A;
            end
            RUN: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  if (wr_en) begin
                     HI <= temp_hi;
                     LO <= temp_lo;
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign MDUout = rd_sel ? HI : LO;
endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multi-cycle multiply/divide unit in the Execute stage of the pipelined MIPS core, alongside the single-cycle ALU. It executes mult, multu, div, divu, mthi and mtlo, holds the architectural HI/LO registers, and drives mfhi/mflo read data. A busy indication lets the hazard unit stall dependent MD instructions in Decode.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu.
- DIV_CYCLES, 10, busy duration for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- A  input  32  rs operand (forwarded E-stage value).
- B  input  32  rt operand (forwarded E-stage value).
- MDUctrl  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
- start  input  1  one-cycle pulse; MDUctrl is valid in this cycle.
- req  input  1  exception/interrupt flush; when high, this cycle's start is squashed.
- rd_sel  input  1  read select: 1 HI, 0 LO.
- MDUout  output  32  rd_sel ? HI : LO. Combinational from registers.
- busy  output  1  unit occupied by a mult/div.
- HI, LO  output  32 each  architectural registers.

## Operation
- Accept: a start is accepted on a rising edge when start=1, req=0 and busy=0. The op is taken from MDUctrl. If start=1 while busy=1, it is ignored; upstream must never issue it.
- mult/multu/div/divu:
  - The 64-bit result is computed from A/B at the accepting edge and held in internal temp_hi/temp_lo.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES, and busy goes to 1.
- mthi/mtlo: at the accepting edge, HI<=A or LO<=A. busy stays 0, and the write is visible in the next cycle.
- mult: signed 32x32 product; HI=[63:32], LO=[31:0]. multu is the same, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (A).
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0, div or divu): the unit still goes busy for DIV_CYCLES, and HI/LO remain unchanged at completion.
- States: IDLE (busy=0) and RUN (busy=1, counter>0).
  - IDLE to RUN on an accepted mult/div.
  - RUN: counter decrements each edge. On the edge where the counter goes 1 to 0, HI/LO load the temp values and the unit returns to IDLE.
- req during RUN does not cancel the operation, because it was committed when accepted.
- Hazard contract: Decode stalls any mfhi/mflo/mthi/mtlo/mult/div while (start || busy).

## Timing
- Reset (async, reset=0):
  - HI=0, LO=0, busy=0, MDUout=0, counter=0, temp regs=0.
  - Any in-flight op is discarded and does not complete after release.
- Latency: for a start accepted at edge E0, busy is 1 from E0 until edge E0+N, where N=MULT_CYCLES or DIV_CYCLES.
  - busy is high for exactly N cycles.
  - HI/LO update at edge E0+N, and busy=0 in the same cycle the new values appear.
- A new start may be accepted at edge E0+N+1 at the earliest, i.e. the first edge with busy=0.
- HI/LO are never partially updated and never change while busy=1.
- MDUout follows rd_sel combinationally within the same cycle.
- Simultaneous start and req: no state change at all, including for mthi/mtlo.

## Test plan
- Reset then mult with A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Before completion, HI=LO=0.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div with A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Follow with div 0x80000000/-1 -> LO=0x80000000, HI=0.
- mthi A=0x12345678, then divu with B=0:
  - mthi gives HI=0x12345678 next cycle, and MDUout=0x12345678 with rd_sel=1.
  - The divu still keeps busy high 10 cycles, and HI/LO are unchanged at completion.
- start with MDUctrl=1 and req=1 -> busy stays 0, HI/LO unchanged.
  - A start during busy is ignored.
  - Assert reset at cycle 3 of a mult -> busy=0, HI=LO=0 immediately, and no update after reset is released.
